// File: rtl/dmem_bus_pkg.sv
// Shared encodings for the data-memory SRAM-like bus bridge.
package dmem_bus_pkg;

  // Bus size encodings (mem_size / size)
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bridgeState_t;

  // kseg0/kseg1 occupy 0x8000_0000-0xBFFF_FFFF: top two address bits = 2'b10
  localparam logic [1:0]  KSEG01_TOP     = 2'b10;
  localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

  function automatic logic isKseg01(input logic [1:0] topBits);
    return topBits == KSEG01_TOP;
  endfunction

endpackage

// File: rtl/dmem_addr_map.sv
// Combinational MIPS virtual->physical map: kseg0/kseg1 strip the top three bits,
// every other segment passes through unchanged.
module dmem_addr_map
  import dmem_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] vAddr,
  output logic [ADDR_W-1:0] pAddr
);

  // Unmapped segments fold onto physical low memory
  always_comb begin
    pAddr = vAddr;
    if (isKseg01(vAddr[ADDR_W-1 -: 2])) begin
      pAddr = vAddr & ADDR_W'(KSEG_PHYS_MASK);
    end
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// M-stage data-memory port to SRAM-like req/addr_ok/data_ok bus bridge.
// Raises mem_stall for the duration of an access and holds load data while
// the pipeline is frozen by another stall source.
// Optional feature: define DMEM_ADDR_MAP_EN to map kseg0/kseg1 addresses to physical.
module dmem_sram_bridge
  import dmem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic [DATA_W/8-1:0]   mem_wen,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_flush,
  input  logic                  cpu_stall,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_stall,
  output logic                  req,
  output logic                  wr,
  output logic [1:0]            size,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  input  logic                  addr_ok,
  input  logic                  data_ok,
  input  logic [DATA_W-1:0]     rdata
);

  bridgeState_t      state, stateNext;
  logic              discard, discardNext;
  logic              captureRdata;
  logic [DATA_W-1:0] rdataQ;

  logic [ADDR_W-1:0] addrIn;
  logic              wrIn;
  logic              accessReq;

  logic [ADDR_W-1:0] addrQ;
  logic              wrQ;
  logic [1:0]        sizeQ;
  logic [DATA_W-1:0] wdataQ;

`ifdef DMEM_ADDR_MAP_EN
  dmem_addr_map #(.ADDR_W(ADDR_W)) uAddrMap (
    .vAddr (mem_addr),
    .pAddr (addrIn)
  );
`else
  assign addrIn = mem_addr;
`endif

  assign wrIn      = |mem_wen;
  assign accessReq = mem_en & ~mem_flush;

  // State, discard flag and held load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      discard <= 1'b0;
      rdataQ  <= '0;
    end else begin
      state   <= stateNext;
      discard <= discardNext;
      if (captureRdata) begin
        rdataQ <= rdata;
      end
    end
  end

  // Request fields tracked while idle so they stay stable until addr_ok
  always_ff @(posedge clk) begin
    if (rst) begin
      addrQ  <= '0;
      wrQ    <= 1'b0;
      sizeQ  <= SIZE_BYTE;
      wdataQ <= '0;
    end else if (state == IDLE) begin
      addrQ  <= addrIn;
      wrQ    <= wrIn;
      sizeQ  <= mem_size;
      wdataQ <= mem_wdata;
    end
  end

  // Next state, bus request and stall generation
  always_comb begin
    stateNext    = state;
    discardNext  = discard;
    captureRdata = 1'b0;
    req          = 1'b0;
    mem_stall    = 1'b0;
    addr         = addrQ;
    wr           = wrQ;
    size         = sizeQ;
    wdata        = wdataQ;
    unique case (state)
      IDLE: begin
        addr      = addrIn;
        wr        = wrIn;
        size      = mem_size;
        wdata     = mem_wdata;
        req       = accessReq;
        mem_stall = accessReq;
        if (accessReq) begin
          stateNext = addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        req       = 1'b1;
        mem_stall = 1'b1;
        if (addr_ok) begin
          // a flush racing the acceptance still has to drain its response
          stateNext   = WAIT;
          discardNext = mem_flush;
        end else if (mem_flush) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        mem_stall = ~(data_ok & ~discard);
        if (data_ok) begin
          captureRdata = ~discard;
          discardNext  = 1'b0;
          stateNext    = (~discard & cpu_stall) ? DONE : IDLE;
        end else if (mem_flush) begin
          discardNext = 1'b1;
        end
      end
      DONE: begin
        if (!cpu_stall) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bus data passes straight through in the response cycle; a drained response never shows
  assign mem_rdata = captureRdata ? rdata : rdataQ;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Randomized scoreboard bench for dmem_sram_bridge with a behavioural bus slave
// and a program-order reference memory.
`timescale 1ns/1ps
module tb_dmem_sram_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_flush;
  logic        cpu_stall;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  dmem_sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_flush (mem_flush),
    .cpu_stall (cpu_stall),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata)
  );

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } busReq_t;

  typedef struct {
    logic        isLoad;
    logic [31:0] data;
  } cpuExp_t;

  busReq_t     busQ[$];
  cpuExp_t     cpuQ[$];
  logic [31:0] refMem[logic [31:0]];
  logic [31:0] slaveMem[logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic failNow(input string name);
    nChecks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Physical address seen on the bus for a CPU virtual address
  function automatic logic [31:0] physAddr(input logic [31:0] a);
`ifdef DMEM_ADDR_MAP_EN
    if (a >= 32'hA000_0000 && a <= 32'hBFFF_FFFF) return a - 32'hA000_0000;
    if (a >= 32'h8000_0000 && a <= 32'h9FFF_FFFF) return a - 32'h8000_0000;
`endif
    return a;
  endfunction

  function automatic logic [31:0] initWord(input logic [31:0] w);
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] readRef(input logic [31:0] pa);
    logic [31:0] w;
    w = pa & ~32'h3;
    return refMem.exists(w) ? refMem[w] : initWord(w);
  endfunction

  // ---------------- bus slave ----------------
  initial begin : slave
    logic        outstanding;
    logic        waiting;
    int          accDly;
    int          dataDly;
    logic [31:0] resp;
    logic [31:0] w;
    logic [31:0] cur;
    outstanding = 1'b0;
    waiting     = 1'b0;
    accDly      = 0;
    dataDly     = 0;
    resp        = '0;
    addr_ok     = 1'b0;
    data_ok     = 1'b0;
    rdata       = '0;
    forever begin
      @(posedge clk);
      #2;
      addr_ok = 1'b0;
      data_ok = 1'b0;
      if (rst) begin
        outstanding = 1'b0;
        waiting     = 1'b0;
        continue;
      end
      if (outstanding) begin
        if (!mem_flush) begin
          if (dataDly == 0) begin
            data_ok     = 1'b1;
            rdata       = resp;
            outstanding = 1'b0;
          end else dataDly--;
        end
      end else if (req) begin
        if (!waiting) begin
          waiting = 1'b1;
          accDly  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        end
        if (!mem_flush) begin
          if (accDly == 0) begin
            addr_ok     = 1'b1;
            waiting     = 1'b0;
            outstanding = 1'b1;
            dataDly     = $urandom_range(0, 3);
            w   = addr & ~32'h3;
            cur = slaveMem.exists(w) ? slaveMem[w] : initWord(w);
            if (wr) begin
              case (size)
                2'd0:    cur[{addr[1:0], 3'b000} +: 8]  = wdata[{addr[1:0], 3'b000} +: 8];
                2'd1:    cur[{addr[1], 4'b0000} +: 16]  = wdata[{addr[1], 4'b0000} +: 16];
                default: cur = wdata;
              endcase
              slaveMem[w] = cur;
              resp = $urandom;
            end else begin
              resp = cur;
            end
          end else accDly--;
        end
      end else begin
        waiting = 1'b0;
      end
    end
  end

  // ---------------- bus-side monitor ----------------
  initial begin : busMon
    logic    dropPending;
    logic    holdPending;
    busReq_t prev;
    busReq_t e;
    dropPending = 1'b0;
    holdPending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dropPending = 1'b0;
        holdPending = 1'b0;
        continue;
      end
      if (dropPending) begin
        check("req after REQ flush", req, 1'b0);
        check("stall after REQ flush", mem_stall, 1'b0);
        dropPending = 1'b0;
      end
      if (holdPending) begin
        check("req held", req, 1'b1);
        check("held addr", addr, prev.addr);
        check("held wdata", wdata, prev.wdata);
        check("held size", size, prev.size);
        holdPending = 1'b0;
      end
      if (req && (addr_ok || mem_flush)) begin
        if (busQ.size() == 0) failNow("unexpected bus request");
        else begin
          e = busQ.pop_front();
          check("bus addr", addr, e.addr);
          check("bus wr", wr, e.wr);
          check("bus size", size, e.size);
          check("bus wdata", wdata, e.wdata);
        end
        if (mem_flush && !addr_ok) dropPending = 1'b1;
      end else if (req) begin
        holdPending = 1'b1;
        prev = '{addr, wr, size, wdata};
      end
    end
  end

  // ---------------- cpu-side monitor ----------------
  initial begin : cpuMon
    cpuExp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (data_ok) begin
        if (mem_en) check("stall in response cycle", mem_stall, 1'b0);
        else        check("stall in drained response", mem_stall, 1'b1);
      end
      if (mem_en && mem_flush) begin
        if (cpuQ.size() == 0) failNow("flush with empty cpu queue");
        else void'(cpuQ.pop_front());
      end else if (mem_en && !mem_stall) begin
        if (cpuQ.size() == 0) failNow("retire with empty cpu queue");
        else begin
          e = cpuQ[0];
          if (e.isLoad) check("load data", mem_rdata, e.data);
          if (!cpu_stall) void'(cpuQ.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic runInstr();
    logic [31:0] va, pa, wd, cur;
    logic [1:0]  sz;
    logic [3:0]  wen;
    logic        isLoad, accepted, reqPending, gotData, flushed, done;
    int          mode;
    sz = 2'($urandom_range(0, 2));
    case ($urandom_range(0, 3))
      0:       va = 32'h0000_1000;
      1:       va = 32'h8000_1000;
      2:       va = 32'hA000_1000;
      default: va = 32'hC000_1000;
    endcase
    va = va + 32'($urandom_range(0, 15)) * 4;
    if (sz == 2'd0) va = va + 32'($urandom_range(0, 3));
    if (sz == 2'd1) va = va + 32'($urandom_range(0, 1)) * 2;
    isLoad = 1'($urandom_range(0, 1));
    wd     = $urandom;
    wen    = 4'b0000;
    if (!isLoad) begin
      case (sz)
        2'd0: begin wen = 4'b0001 << va[1:0];          wd = {4{wd[7:0]}};  end
        2'd1: begin wen = 4'b0011 << {va[1], 1'b0};    wd = {2{wd[15:0]}}; end
        default: wen = 4'b1111;
      endcase
    end
    mode = $urandom_range(0, 9);
    pa   = physAddr(va);
    if (mode != 0) busQ.push_back('{pa, !isLoad, sz, wd});
    cpuQ.push_back('{isLoad, readRef(pa)});

    accepted = 1'b0; reqPending = 1'b0; gotData = 1'b0; flushed = 1'b0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        mem_en = 1'b1; mem_wen = wen; mem_size = sz; mem_addr = va; mem_wdata = wd;
      end
      mem_flush = (c == 0 && mode == 0) ||
                  (mode == 1 && reqPending && !accepted) ||
                  (mode == 2 && isLoad && accepted && !gotData);
      cpu_stall = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (req && addr_ok) accepted = 1'b1;
      reqPending = req && !addr_ok;
      if (data_ok) gotData = 1'b1;
      if (mem_flush) begin
        flushed = 1'b1;
        done    = 1'b1;
      end else if (!mem_stall && !cpu_stall) done = 1'b1;
    end
    if (!done) failNow("access did not complete");
    if (!flushed && !isLoad) begin
      cur = readRef(pa);
      for (int b = 0; b < 4; b++) if (wen[b]) cur[8*b +: 8] = wd[8*b +: 8];
      refMem[pa & ~32'h3] = cur;
    end
    if (flushed) begin
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
        @(posedge clk);
        #1;
        mem_en = 1'b0; mem_flush = 1'b0; cpu_stall = 1'b0;
        @(negedge clk);
        done = !mem_stall;
      end
      if (!done) failNow("bubble after flush did not drain");
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic hs;
    rst = 1'b1; mem_en = 1'b0; mem_wen = '0; mem_size = '0; mem_addr = '0;
    mem_wdata = '0; mem_flush = 1'b0; cpu_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req", req, 1'b0);
    check("reset mem_stall", mem_stall, 1'b0);
    check("reset mem_rdata", mem_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 300; i++) runInstr();

    // load left waiting for its response when rst hits
    @(posedge clk);
    #1;
    mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h0000_1000;
    mem_flush = 1'b0; cpu_stall = 1'b0;
    busQ.push_back('{physAddr(32'h0000_1000), 1'b0, 2'd2, mem_wdata});
    cpuQ.push_back('{1'b1, readRef(physAddr(32'h0000_1000))});
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = req && addr_ok;
      if (!hs) @(posedge clk);
    end
    if (!hs) failNow("reset-test handshake");
    @(posedge clk);
    #1;
    rst = 1'b1; mem_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpuQ.delete();
    @(negedge clk);
    check("post-rst req", req, 1'b0);
    check("post-rst mem_stall", mem_stall, 1'b0);
    check("post-rst mem_rdata", mem_rdata, 32'h0);

    for (int i = 0; i < 40; i++) runInstr();

    @(posedge clk);
    #1;
    mem_en = 1'b0; mem_flush = 1'b0; cpu_stall = 1'b0;
    repeat (3) @(negedge clk);
    check("bus queue drained", busQ.size(), 32'd0);
    check("cpu queue drained", cpuQ.size(), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
